dmem_mmio_bus: RTL and testbench
================================

Name: dmem_mmio_bus

Overview:
- Data-side memory subsystem directly downstream of the single-cycle RV32 core.
- Consumes the core's MemWrite/ALUResult/WriteData and returns ReadData in the same cycle.
- Decodes each access to a word RAM, a free-running compare timer, or a byte TX FIFO feeding an 8N1 serial transmitter.
- The only sequential path back to the core is the timer interrupt line.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, ≤1024.
- TX_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- BAUD_DIV, 16, clk cycles per serial bit; ≥2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- mem_write  in  1  store strobe from core (MemWrite).
- addr  in  32  byte address (ALUResult); addr[1:0] ignored.
- wdata  in  32  store data (WriteData).
- rdata  out  32  load data (ReadData); combinational from addr.
- tx  out  1  serial output; idles high.
- irq  out  1  timer interrupt, level.

Behaviour:
- Reads are combinational: rdata is a function of addr and current state, with zero cycle latency.
- Writes commit at the posedge where mem_write=1.
- There is no read strobe; reads have no side effects.

Address map:
- RAM at 0x0000_0000 up to RAM_WORDS*4-1. Indexed by addr[log2(RAM_WORDS)+1:2]. RAM is not reset; its contents after reset are undefined.
- 0x1000 TCOUNT (R/W, 32b).
- 0x1004 TCMP (R/W, 32b).
- 0x1008 TCTRL (R/W):
  - bit0 enable, bit1 irq_en: normal R/W.
  - bit2 pending: write 1 to clear, write 0 has no effect.
  - Other bits read 0.
- 0x100C TXDATA (W): pushes wdata[7:0]. Reads as 0.
- 0x1010 TXSTAT (R):
  - bit0 full, bit1 empty, bit2 busy.
  - bit3 overflow (sticky; write 1 to this address's bit3 to clear).
  - bits[15:8] FIFO count.
  - Other bits 0.
- Any other address: reads 0, writes ignored.

Timer:
- When enable=1, TCOUNT increments by 1 each cycle.
- If TCOUNT==TCMP at an edge, TCOUNT becomes 0 and pending is set. Wrap at 0xFFFFFFFF to 0 is natural.
- A store to TCOUNT overrides the increment/clear in that cycle.
- Setting pending (compare match) beats a write-1-clear in the same cycle.
- irq = pending & irq_en (registered state, combinational AND).

TX FIFO:
- A push is accepted if count<TX_DEPTH, or if a pop occurs in the same cycle.
- Otherwise the byte is dropped and overflow is set.
- Pop occurs at an edge where the serializer is idle and count>0.
- Simultaneous push and pop: count unchanged; the data order is preserved.
- Pointers wrap modulo TX_DEPTH.

Serializer FSM:
- States: IDLE, START, DATA, STOP.
- tx is registered.
- IDLE→START at the pop edge: byte loaded, tx=0 for BAUD_DIV cycles.
- DATA: 8 bits LSB first, BAUD_DIV cycles each.
- STOP: tx=1 for BAUD_DIV cycles.
- At the end of STOP:
  - If the FIFO is non-empty, pop and go to START immediately, with no extra idle bit.
  - Otherwise go to IDLE.
- busy=1 in any state other than IDLE.
- A frame is 10*BAUD_DIV cycles.
- Push into an empty FIFO with the serializer idle at edge N: pop at edge N+1, tx falls after edge N+1.

Reset (asynchronous, any time including mid-frame):
- TCOUNT, TCMP, TCTRL = 0.
- FIFO empty, overflow = 0.
- FSM = IDLE.
- tx=1 and irq=0 immediately.
- Bit counter and baud counter = 0.

Test Plan:
- RAM: store 0xDEADBEEF to 0x0000_0010, then load 0x10 and 0x13 → both return 0xDEADBEEF. Load 0x2000 → 0.
- Timer: TCMP=5, TCTRL=0b011 → irq rises after the 6th enabled edge with TCOUNT=0. Write TCTRL=0b111 → irq=0, then irq re-asserts 6 edges later.
- Timer conflict: store TCOUNT=100 in the same cycle the count would have incremented → reads 100. Compare-set and clear in the same edge → pending stays 1.
- TX frame, BAUD_DIV=4: push 0xA5 →
  - tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles.
  - busy=1 for 40 cycles.
- FIFO full: push 10 bytes back-to-back while a frame is active →
  - 1 byte in the serializer, 8 in the FIFO, 1 dropped.
  - TXSTAT reports full=1, overflow=1, count=8.
  - All 9 bytes are transmitted in order with no idle gap.
  - Write TXSTAT bit3 → overflow=0.
- Reset mid-frame (assert between edges during the DATA state) → tx=1 and irq=0 immediately. TXSTAT=0x0000_0002 after release.

Source files
------------

// File: rtl/dmem_mmio_bus.sv
// dmem_mmio_bus: data-side RAM, compare timer and 8N1 TX FIFO behind a combinational load path
module dmem_mmio_bus #(
  parameter int RAM_WORDS = 64,
  parameter int TX_DEPTH  = 8,
  parameter int BAUD_DIV  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_tx,
  output logic        o_irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [31:0]   r_ram [RAM_WORDS];
  logic [7:0]    r_fifo [TX_DEPTH];
  logic [31:0]   r_tcount, r_tcmp;
  logic          r_en, r_irq_en, r_pend;
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic [BW-1:0] r_baud;
  logic          r_tx;

  logic [29:0]   w_word;
  logic [AW-1:0] w_ram_idx;
  logic          w_ram_sel, w_sel_tcount, w_sel_tcmp, w_sel_tctrl, w_sel_txdata, w_sel_txstat;
  logic          w_match, w_baud_end, w_pop, w_push_req, w_push;
  logic          w_full, w_empty, w_busy;
  logic          w_unused;

  assign w_word       = i_addr[31:2];
  assign w_ram_idx    = i_addr[AW+1:2];
  assign w_ram_sel    = i_addr[31:AW+2] == '0;
  assign w_sel_tcount = w_word == 30'h400;
  assign w_sel_tcmp   = w_word == 30'h401;
  assign w_sel_tctrl  = w_word == 30'h402;
  assign w_sel_txdata = w_word == 30'h403;
  assign w_sel_txstat = w_word == 30'h404;
  assign w_unused     = ^i_addr[1:0];

  assign w_match    = r_en && (r_tcount == r_tcmp);
  assign w_baud_end = r_baud == BW'(BAUD_DIV - 1);
  assign w_full     = r_cnt == CW'(TX_DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_busy     = r_state != IDLE;
  // The serializer only takes a byte when it is idle or finishing a stop bit, so back-to-back frames have no gap.
  assign w_pop      = !w_empty && (r_state == IDLE || (r_state == STOP && w_baud_end));
  assign w_push_req = i_mem_write && w_sel_txdata;
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign o_tx  = r_tx;
  assign o_irq = r_pend & r_irq_en;

  // Zero-latency load mux; unmapped addresses read as zero.
  always_comb begin
    o_rdata = w_ram_sel    ? r_ram[w_ram_idx] :
              w_sel_tcount ? r_tcount :
              w_sel_tcmp   ? r_tcmp :
              w_sel_tctrl  ? {29'b0, r_pend, r_irq_en, r_en} :
              w_sel_txstat ? {16'b0, 8'(r_cnt), 4'b0, r_ovf, w_busy, w_empty, w_full} :
                             32'b0;
  end

  // Word RAM, deliberately unreset.
  always_ff @(posedge clk) begin
    if (i_mem_write && w_ram_sel) r_ram[w_ram_idx] <= i_wdata;
  end

  // FIFO byte storage, unreset; occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= i_wdata[7:0];
  end

  // Compare timer: a store to TCOUNT wins over count/clear, a match wins over a pending clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcount <= '0;
      r_tcmp   <= '0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_tcount <= (i_mem_write && w_sel_tcount) ? i_wdata : w_match ? '0 : r_en ? r_tcount + 32'd1 : r_tcount;
      if (i_mem_write && w_sel_tcmp) r_tcmp <= i_wdata;
      if (i_mem_write && w_sel_tctrl) begin
        r_en     <= i_wdata[0];
        r_irq_en <= i_wdata[1];
      end
      r_pend <= w_match | (r_pend & ~(i_mem_write & w_sel_tctrl & i_wdata[2]));
    end
  end

  // FIFO pointers, occupancy and sticky overflow for dropped pushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wp  <= r_wp + PW'(w_push);
      r_rp  <= r_rp + PW'(w_pop);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_ovf <= (w_push_req && !w_push) ? 1'b1 : (i_mem_write && w_sel_txstat && i_wdata[3]) ? 1'b0 : r_ovf;
    end
  end

  // 8N1 serializer, LSB first, BAUD_DIV clocks per bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_pop) begin
          r_state <= START;
          r_shift <= r_fifo[r_rp];
          r_baud  <= '0;
          r_tx    <= 1'b0;
        end
        START: if (w_baud_end) begin
          r_state <= DATA;
          r_tx    <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_bit   <= '0;
          r_baud  <= '0;
        end else r_baud <= r_baud + 1'b1;
        DATA: if (w_baud_end) begin
          r_baud <= '0;
          if (r_bit == 3'd7) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
          end
        end else r_baud <= r_baud + 1'b1;
        STOP: if (w_baud_end) begin
          r_baud <= '0;
          if (w_pop) begin
            r_state <= START;
            r_shift <= r_fifo[r_rp];
            r_tx    <= 1'b0;
          end else r_state <= IDLE;
        end else r_baud <= r_baud + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_mmio_bus.sv
// tb_dmem_mmio_bus: register vectors, timer/TX sequences and a serial-receive scoreboard
module tb_dmem_mmio_bus;
  localparam int B = 4;

  logic        clk, reset, mem_write, tx, irq;
  logic [31:0] addr, wdata, rdata;
  int          total = 0, bad = 0, cyc = 0;
  logic        mon_on = 1'b1;
  logic [7:0]  sb [$];
  int          starts [$];

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t vecs [$];

  dmem_mmio_bus #(.RAM_WORDS(64), .TX_DEPTH(8), .BAUD_DIV(B)) dut (
    .clk(clk), .reset(reset), .i_mem_write(mem_write), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_tx(tx), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1 mem_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    @(negedge clk);
    check(name, rdata, e);
  endtask

  // Serial receiver: decodes frames and compares against bytes queued at push time.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_on && !reset && tx === 1'b0) begin
        starts.push_back(cyc);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = tx;
        end
        repeat (B) @(negedge clk);
        check("rx_stop", 32'(tx), 32'd1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %h expected no frame", b);
        end else check("rx_byte", 32'(b), 32'(sb.pop_front()));
        repeat (B - 1) @(negedge clk);
      end
    end
  end

  initial begin
    logic [7:0] a5 = 8'hA5;
    logic       eb;
    int         k;
    vecs.push_back({1'b0, 32'h1000, 32'h0, 32'h0});
    vecs.push_back({1'b0, 32'h1004, 32'h0, 32'h0});
    vecs.push_back({1'b0, 32'h1008, 32'h0, 32'h0});
    vecs.push_back({1'b0, 32'h1010, 32'h0, 32'h2});
    vecs.push_back({1'b1, 32'h0010, 32'hDEADBEEF, 32'h0});
    vecs.push_back({1'b0, 32'h0010, 32'h0, 32'hDEADBEEF});
    vecs.push_back({1'b0, 32'h0013, 32'h0, 32'hDEADBEEF});
    vecs.push_back({1'b0, 32'h2000, 32'h0, 32'h0});
    vecs.push_back({1'b1, 32'h2000, 32'h12345678, 32'h0});
    vecs.push_back({1'b0, 32'h2000, 32'h0, 32'h0});
    vecs.push_back({1'b1, 32'h00FC, 32'h11223344, 32'h0});
    vecs.push_back({1'b0, 32'h00FC, 32'h0, 32'h11223344});
    vecs.push_back({1'b1, 32'h0000, 32'h0, 32'h0});
    vecs.push_back({1'b1, 32'h0100, 32'hBAD0BAD0, 32'h0});
    vecs.push_back({1'b0, 32'h0000, 32'h0, 32'h0});
    vecs.push_back({1'b0, 32'h0100, 32'h0, 32'h0});
    vecs.push_back({1'b1, 32'h1004, 32'h5, 32'h0});
    vecs.push_back({1'b0, 32'h1004, 32'h0, 32'h5});
    vecs.push_back({1'b1, 32'h1008, 32'hFFFFFFF8, 32'h0});
    vecs.push_back({1'b0, 32'h1008, 32'h0, 32'h0});
    vecs.push_back({1'b0, 32'h100C, 32'h0, 32'h0});
    vecs.push_back({1'b1, 32'h1000, 32'h77, 32'h0});
    vecs.push_back({1'b0, 32'h1000, 32'h0, 32'h77});
    vecs.push_back({1'b1, 32'h1010, 32'hFFFFFFFF, 32'h0});
    vecs.push_back({1'b0, 32'h1010, 32'h0, 32'h2});

    reset = 1'b1;
    mem_write = 1'b0;
    addr = '0;
    wdata = '0;
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].we) wr(vecs[i].a, vecs[i].d);
      else rd($sformatf("vec%0d", i), vecs[i].a, vecs[i].e);

    wr(32'h1000, 0);
    wr(32'h1004, 5);
    wr(32'h1008, 3);
    addr = 32'h1000;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("tcount%0d", i), rdata, (i == 6) ? 32'd0 : 32'(i));
      check($sformatf("irq%0d", i), 32'(irq), 32'(i == 6));
    end
    wr(32'h1008, 7);
    addr = 32'h1000;
    #1;
    check("clr_tcount", rdata, 32'd1);
    check("clr_irq", 32'(irq), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1 check($sformatf("reirq%0d", i), 32'(irq), 32'(i == 5));
    end
    wr(32'h1000, 100);
    addr = 32'h1000;
    #1 check("store_wins", rdata, 32'd100);
    @(posedge clk);
    #1 check("count_on", rdata, 32'd101);
    wr(32'h1008, 7);
    #1 check("clr2_irq", 32'(irq), 32'd0);
    wr(32'h1000, 4);
    addr = 32'h1000;
    @(posedge clk);
    #1;
    check("pre_match", rdata, 32'd5);
    check("pre_match_irq", 32'(irq), 32'd0);
    wr(32'h1008, 7);
    addr = 32'h1000;
    #1;
    check("match_wrap", rdata, 32'd0);
    check("set_beats_clr", 32'(irq), 32'd1);
    wr(32'h1008, 4);
    #1 check("timer_off", rdata, 32'd0);

    sb.push_back(a5);
    wr(32'h100C, 32'hA5);
    addr = 32'h1010;
    #1 check("a5_queued", rdata, 32'h100);
    for (int c = 0; c < 10 * B; c++) begin
      @(posedge clk);
      #1;
      eb = (c / B == 0) ? 1'b0 : (c / B == 9) ? 1'b1 : a5[c / B - 1];
      check($sformatf("a5_c%0d", c), {30'b0, tx, rdata[2]}, {30'b0, eb, 1'b1});
    end
    @(posedge clk);
    #1 check("a5_done", rdata, 32'h2);

    starts.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(8'(8'h30 + i));
      wr(32'h100C, 32'(8'h30 + i));
    end
    addr = 32'h1010;
    #1 check("full_stat", rdata, 32'h80D);
    wr(32'h1010, 32'h8);
    addr = 32'h1010;
    #1 check("ovf_clr", rdata, 32'h805);
    k = 0;
    while ((sb.size() != 0 || rdata != 32'h2) && k < 600) begin
      @(posedge clk);
      #1 k++;
    end
    check("drain_timeout", 32'(k < 600), 32'd1);
    check("frames", 32'(starts.size()), 32'd9);
    for (int i = 1; i < starts.size(); i++)
      check($sformatf("gap%0d", i), 32'(starts[i] - starts[i-1]), 32'(10 * B));

    wr(32'h1000, 0);
    wr(32'h1004, 1);
    wr(32'h1008, 3);
    mon_on = 1'b0;
    wr(32'h100C, 32'h00);
    repeat (12) @(posedge clk);
    #1;
    check("mid_tx", 32'(tx), 32'd0);
    check("mid_irq", 32'(irq), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async_tx", 32'(tx), 32'd1);
    check("async_irq", 32'(irq), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    addr = 32'h1010;
    #1 check("post_stat", rdata, 32'h2);
    addr = 32'h1008;
    @(posedge clk);
    #1;
    check("post_tctrl", rdata, 32'h0);
    check("post_tx", 32'(tx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
